// File: rtl/pwm_dac_pkg.sv
// Shared types, scaling constants and the millivolt-to-code helper for the
// PWM/R2R DAC output path.
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } dac_state_t;

  localparam logic [23:0] MV_TO_CODE_MUL = 24'd79;
  localparam logic [23:0] MV_ROUND       = 24'd512;
  localparam int          MV_SHIFT       = 32'd10;
  localparam logic [15:0] FULL_SCALE_MV  = 16'd3300;
  localparam logic [7:0]  CODE_MAX       = 8'hFF;

  // 3300 mV maps to ~255 with a 79/1024 gain; anything at or above full
  // scale, or rounding past 255, is clamped to the top code.
  function automatic logic [7:0] mv_to_code(input logic [15:0] mv);
    logic [23:0] scaled;
    scaled = (({8'd0, mv} * MV_TO_CODE_MUL) + MV_ROUND) >> MV_SHIFT;
    if ((mv >= FULL_SCALE_MV) || (scaled > {16'd0, CODE_MAX})) begin
      return CODE_MAX;
    end else begin
      return scaled[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_dac_sync_fifo.sv
// Synchronous show-ahead FIFO with flush. DEPTH must be a power of two so
// the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign level     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM / R2R DAC output stage: scales millivolt samples to 8-bit codes,
// buffers them and plays them out at a fixed sample rate. Duty changes are
// applied only at the PWM period boundary so the output never glitches.
// Optional feature macro: PWM_DAC_UNDERRUN_CNT_EN (saturating underrun count).
module pwm_dac_out
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int SAMPLE_FREQ_HZ = 10_000,
  parameter int FIFO_DEPTH     = 16,
  parameter int PRIME_LEVEL    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   din_mv,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          pwm_out,
  output logic [WIDTH-1:0]              r2r_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam int TICK_PERIOD = CLOCK_FREQ / SAMPLE_FREQ_HZ;
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

  dac_state_t        state_r;
  dac_state_t        state_nxt_s;
  logic              go_idle_s;
  logic              accept_s;
  logic              tick_s;
  logic              pop_s;
  logic              underrun_evt_s;
  logic              fifo_push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [LVL_W-1:0]  level_s;
  logic [WIDTH-1:0]  fifo_dout_s;
  logic              stage_valid_r;
  logic [WIDTH-1:0]  stage_code_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [WIDTH-1:0]  pending_r;
  logic              sample_tick_r;
  logic              underrun_r;
  logic [WIDTH-1:0]  pwm_cnt_r;
  logic [WIDTH-1:0]  pwm_cnt_nxt_s;
  logic [WIDTH-1:0]  duty_r;
  logic [WIDTH-1:0]  duty_nxt_s;
  logic              pwm_out_r;

  // Leaving any active state flushes the buffer and silences the outputs.
  assign go_idle_s = (state_r != IDLE) && !enable;

  // The staged sample counts against capacity so a push can never overflow.
  assign din_ready = !fifo_full_s &&
                     (({1'b0, level_s} + (LVL_W+1)'(stage_valid_r)) < (LVL_W+1)'(FIFO_DEPTH));
  assign accept_s    = din_valid && din_ready;
  assign fifo_push_s = stage_valid_r && !go_idle_s;

  assign tick_s         = (state_r != IDLE) && (tick_cnt_r == TICK_W'(TICK_PERIOD - 1));
  assign pop_s          = tick_s && (state_r == RUN) && !fifo_empty_s && !go_idle_s;
  assign underrun_evt_s = tick_s && (state_r == RUN) && fifo_empty_s && !go_idle_s;

  assign pwm_cnt_nxt_s = pwm_cnt_r + WIDTH'(1);
  assign duty_nxt_s    = (pwm_cnt_r == {WIDTH{1'b1}}) ? pending_r : duty_r;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (go_idle_s),
    .push  (fifo_push_s),
    .din   (stage_code_r),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level_s)
  );

  // Playback state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: wait for enable, prime the buffer, then run until disabled.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = PRIME;
        PRIME: begin
          if (level_s >= LVL_W'(PRIME_LEVEL)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PRIME;
          end
        end
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // One-cycle scaling stage; a sample sitting here on exit to IDLE is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_r <= 1'b0;
      stage_code_r  <= WIDTH'(0);
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        stage_code_r <= WIDTH'(mv_to_code(din_mv));
      end
    end
  end

  // Sample-rate divider, parked at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= TICK_W'(0);
    end else if (go_idle_s || (state_r == IDLE) || tick_s) begin
      tick_cnt_r <= TICK_W'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Per-tick playback: pop into the pending code or flag an underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r     <= WIDTH'(0);
      sample_tick_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else if (go_idle_s) begin
      pending_r     <= WIDTH'(0);
      sample_tick_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      sample_tick_r <= tick_s;
      underrun_r    <= underrun_evt_s;
      if (pop_s) begin
        pending_r <= fifo_dout_s;
      end
    end
  end

  // PWM period counter and duty register; duty only reloads at the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= WIDTH'(0);
      duty_r    <= WIDTH'(0);
      pwm_out_r <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_nxt_s;
      if (go_idle_s) begin
        duty_r    <= WIDTH'(0);
        pwm_out_r <= 1'b0;
      end else begin
        duty_r    <= duty_nxt_s;
        pwm_out_r <= (pwm_cnt_nxt_s < duty_nxt_s);
      end
    end
  end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_r;

  // Saturating underrun counter, cleared whenever playback stops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      urun_cnt_r <= 16'h0000;
    end else if (go_idle_s) begin
      urun_cnt_r <= 16'h0000;
    end else if (underrun_evt_s && (urun_cnt_r != 16'hFFFF)) begin
      urun_cnt_r <= urun_cnt_r + 16'h0001;
    end
  end

  assign underrun_count = urun_cnt_r;
`else
  assign underrun_count = 16'h0000;
`endif

  assign pwm_out     = pwm_out_r;
  assign r2r_out     = duty_r;
  assign sample_tick = sample_tick_r;
  assign underrun    = underrun_r;
  assign fifo_level  = level_s;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out with a code scoreboard: each accepted sample
// queues its expected code, and each playback tick pops one and compares it
// with r2r_out at the following PWM wrap.
module tb_pwm_dac_out;

  localparam int TICK = 800;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] din_mv;
  logic        din_valid;
  logic        din_ready;
  logic        pwm_out;
  logic [7:0]  r2r_out;
  logic        sample_tick;
  logic        underrun;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_count;

  int          chk_cnt  = 0;
  int          fail_cnt = 0;
  logic [7:0]  m_cnt;
  logic [7:0]  sb [$];
  logic [7:0]  cur_code;
  int          wrap_wait;

  always #5 clk = ~clk;

  pwm_dac_out #(
    .WIDTH          (8),
    .CLOCK_FREQ     (100_000_000),
    .SAMPLE_FREQ_HZ (125_000),
    .FIFO_DEPTH     (16),
    .PRIME_LEVEL    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .din_mv         (din_mv),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .pwm_out        (pwm_out),
    .r2r_out        (r2r_out),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count)
  );

  // Reference PWM period counter: free-running from reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= 8'd0;
    else       m_cnt <= m_cnt + 8'd1;
  end

  // A push into a full buffer must never happen.
  always @(negedge clk) begin
    if (reset === 1'b0 && dut.fifo_push_s === 1'b1) begin
      chk_cnt++;
      assert (dut.fifo_full_s !== 1'b1)
      else begin
        fail_cnt++;
        $error("FAIL push_when_full: observed full=%0b expected 0", dut.fifo_full_s);
      end
    end
  end

  function automatic logic [7:0] exp_code(input int mv);
    int c;
    if (mv >= 3300) return 8'd255;
    c = (mv * 79 + 512) / 1024;
    if (c > 255) c = 255;
    return 8'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int mv, input int limit);
    int waited = 0;
    din_mv    = 16'(mv);
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
    sb.push_back(exp_code(mv));
  endtask

  task automatic wait_tick();
    int waited = 0;
    @(negedge clk);
    while (sample_tick !== 1'b1 && waited < 3 * TICK) begin
      @(negedge clk);
      waited++;
    end
    check("tick_seen", 32'(sample_tick), 32'd1);
    wrap_wait = (m_cnt == 8'd0) ? 256 : 256 - int'(m_cnt);
  endtask

  // Old code must hold until the wrap after the tick; the new one applies there.
  task automatic apply_check(input string tag, input int spent);
    logic [7:0] exp;
    int         remaining;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    exp       = (sb.size() > 0) ? sb.pop_front() : cur_code;
    remaining = wrap_wait - spent;
    if (remaining > 0) begin
      repeat (remaining - 1) @(negedge clk);
      check({tag, "_hold"}, 32'(r2r_out), 32'(cur_code));
      @(negedge clk);
    end
    check({tag, "_apply"}, 32'(r2r_out), 32'(exp));
    cur_code = exp;
  endtask

  task automatic count_high(input string tag, input int exp);
    int hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) hi++;
      @(negedge clk);
    end
    check(tag, 32'(hi), 32'(exp));
  endtask

  task automatic wait_pwm_high(input string tag);
    int waited = 0;
    while (pwm_out !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(pwm_out), 32'd1);
  endtask

  initial begin
    int bp_mv [16] = '{0, 1650, 3300, 5000, 830, 2000, 300, 600,
                       900, 1200, 1500, 1800, 2100, 2400, 2700, 3000};
    logic tick_flag;

    reset     = 1'b1;
    enable    = 1'b0;
    din_valid = 1'b0;
    din_mv    = 16'd0;
    cur_code  = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_r2r_out", 32'(r2r_out), 32'd0);
    check("rst_sample_tick", 32'(sample_tick), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_underrun_count", 32'(underrun_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Backpressure while idle: 16 accepted, 17th stalls
    for (int i = 0; i < 16; i++) send(bp_mv[i], 4);
    din_mv    = 16'd3200;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_ready_low", 32'(din_ready), 32'd0);
    check("bp_level_full", 32'(fifo_level), 32'd16);

    // Playback: first tick frees space and the stalled sample goes in
    enable = 1'b1;
    wait_tick();
    check("bp_pop_level", 32'(fifo_level), 32'd15);
    check("bp_ready_back", 32'(din_ready), 32'd1);
    check("tick1_no_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    sb.push_back(exp_code(3200));
    apply_check("code_0mv", 1);
    check("bp_17th_in", 32'(fifo_level), 32'd16);

    // 1650 mV maps to 0x7F under the 79/1024 gain
    wait_tick();
    check("tick2_no_underrun", 32'(underrun), 32'd0);
    apply_check("code_1650mv", 0);
    wait_tick();
    apply_check("code_3300mv", 0);
    wait_tick();
    apply_check("code_5000mv", 0);
    wait_tick();
    apply_check("code_830mv", 0);
    count_high("bp_duty64_high", 64);
    wait_tick();
    apply_check("code_2000mv", 0);

    // Disable mid-RUN while the output is high
    wait_pwm_high("dis_pwm_high_seen");
    enable = 1'b0;
    @(negedge clk);
    check("dis_pwm_out", 32'(pwm_out), 32'd0);
    check("dis_r2r_out", 32'(r2r_out), 32'd0);
    check("dis_fifo_level", 32'(fifo_level), 32'd0);
    check("dis_din_ready", 32'(din_ready), 32'd1);
    sb.delete();
    cur_code = 8'd0;

    // Priming: three samples are not enough to start playback
    enable = 1'b1;
    send(830, 4);
    send(0, 4);
    send(2500, 4);
    tick_flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sample_tick === 1'b1) tick_flag = 1'b1;
    end
    check("prime_no_tick", 32'(tick_flag), 32'd0);
    check("prime_level3", 32'(fifo_level), 32'd3);
    check("prime_r2r_zero", 32'(r2r_out), 32'd0);
    send(1000, 4);

    wait_tick();
    check("first_pop_level", 32'(fifo_level), 32'd3);
    check("first_pop_no_underrun", 32'(underrun), 32'd0);
    apply_check("prime_830mv", 0);
    count_high("duty64_high", 64);
    wait_tick();
    apply_check("prime_0mv", 0);
    count_high("duty0_high", 0);
    wait_tick();
    apply_check("prime_2500mv", 0);
    wait_tick();
    apply_check("prime_1000mv", 0);

    // Underrun: empty ticks pulse underrun and hold the last code
    for (int k = 1; k <= 2; k++) begin
      wait_tick();
      check("urun_pulse", 32'(underrun), 32'd1);
      check("urun_level", 32'(fifo_level), 32'd0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
      check("urun_count", 32'(underrun_count), 32'(k));
`else
      check("urun_count_tied", 32'(underrun_count), 32'd0);
`endif
      sb.push_back(cur_code);
      apply_check("urun_hold", 0);
    end

    // Asynchronous reset mid-period clears outputs before any clock edge
    wait_pwm_high("arst_pwm_high_seen");
    #2 reset = 1'b1;
    #1;
    check("arst_pwm_out", 32'(pwm_out), 32'd0);
    check("arst_r2r_out", 32'(r2r_out), 32'd0);
    check("arst_fifo_level", 32'(fifo_level), 32'd0);
    check("arst_din_ready", 32'(din_ready), 32'd1);
    check("arst_underrun_count", 32'(underrun_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end

endmodule
